myoquad_multi: RTL and testbench

- Parametrised successor to the two-channel myoquad encoder block.
- Decodes NUM_CHANNELS differential quadrature encoders (4x decoding), with per-channel input synchronisation, glitch filtering, line-fault detection and illegal-transition counting.
- Exposes per-channel position, status and control through an Avalon-MM slave on the HPS lightweight bridge.
- Sits in soc_system next to the myocontrol instances; its conduit goes to encoder GPIO pins.

---
 rtl/myoquad_multi_if.sv | 10 +
 rtl/myoquad_multi.sv | 118 +++++++++++
 tb/tb_myoquad_multi.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/myoquad_multi_if.sv
// myoquad_multi_if: Avalon-MM bus between the HPS lightweight bridge and myoquad_multi
interface myoquad_multi_if;
  logic [7:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  modport master (output address, write, writedata, read, input readdata);
  modport slave (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/myoquad_multi.sv
// myoquad_multi: NUM_CHANNELS filtered differential quadrature decoders behind an Avalon-MM slave.
// Define MYOQUAD_VELOCITY_EN to add a windowed per-channel velocity register (reg 3).
module myoquad_multi #(
  parameter int NUM_CHANNELS = 8,
  parameter int COUNT_WIDTH  = 32,
  parameter int FILTER_DEPTH = 3,
  parameter int VEL_PERIOD   = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  myoquad_multi_if.slave          bus,
  input  logic [NUM_CHANNELS-1:0] quad_apos,
  input  logic [NUM_CHANNELS-1:0] quad_aneg,
  input  logic [NUM_CHANNELS-1:0] quad_bpos,
  input  logic [NUM_CHANNELS-1:0] quad_bneg
);
  // Steps stay suppressed until the filters hold a real post-reset sample, which becomes the baseline
  localparam logic [3:0] WARM_DONE = 4'(FILTER_DEPTH + 4);
  logic [3:0]  warm;
  logic        live, armed;
  logic [5:0]  ch;
  logic [1:0]  rsel;
  logic [31:0] rd_word [NUM_CHANNELS];
  logic [31:0] rd_mux;
  assign ch    = bus.address[7:2];
  assign rsel  = bus.address[1:0];
  assign live  = warm >= 4'd2;
  assign armed = warm == WARM_DONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) warm <= '0;
    else if (!armed) warm <= warm + 4'd1;
`ifdef MYOQUAD_VELOCITY_EN
  localparam int VW = $clog2(VEL_PERIOD + 1);
  logic [VW-1:0] vcnt;
  logic          vel_tick;
  assign vel_tick = vcnt == VW'(VEL_PERIOD - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) vcnt <= '0;
    else vcnt <= vel_tick ? '0 : vcnt + VW'(1);
`endif
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [3:0]              s1, s2;
    logic [FILTER_DEPTH-1:0] ha, hb, ea, eb;
    logic                    fa, fb, pa, pb, bad, moved, illegal, step, up, wr, clr_f, clr_e, fault;
    logic [COUNT_WIDTH-1:0]  pos;
    logic [7:0]              err;
    logic [1:0]              ctrl;
    logic [31:0]             vel_word;
    assign bad     = &ea | &eb;
    assign moved   = armed && {pa, pb} != {fa, fb};
    assign illegal = moved && (pa ^ fa) && (pb ^ fb);
    assign step    = moved && !illegal && ctrl[0];
    assign up      = pa ^ fb ^ ctrl[1];
    assign wr      = bus.write && ch == 6'(c);
    assign clr_f   = wr && rsel == 2'd1 && bus.writedata[8];
    assign clr_e   = wr && rsel == 2'd1 && bus.writedata[9];
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        s1 <= '0;
        s2 <= '0;
        ha <= '0;
        hb <= '0;
        ea <= '0;
        eb <= '0;
        {fa, fb, pa, pb} <= '0;
        fault <= 1'b0;
        err <= '0;
        pos <= '0;
        ctrl <= 2'b01;
      end else begin
        s1 <= {quad_apos[c], quad_aneg[c], quad_bpos[c], quad_bneg[c]};
        s2 <= s1;
        if (live) begin
          ha <= FILTER_DEPTH'({ha, s2[3]});
          hb <= FILTER_DEPTH'({hb, s2[1]});
          ea <= FILTER_DEPTH'({ea, s2[3] == s2[2]});
          eb <= FILTER_DEPTH'({eb, s2[1] == s2[0]});
        end
        if (!bad) begin
          fa <= &ha | (fa & |ha);
          fb <= &hb | (fb & |hb);
        end
        {pa, pb} <= {fa, fb};
        fault <= bad | (fault & !clr_f);
        if (illegal) err <= clr_e ? 8'd1 : err + 8'(err != 8'hff);
        else if (clr_e) err <= '0;
        if (wr && rsel == 2'd0) pos <= bus.writedata[COUNT_WIDTH-1:0];
        else if (step) pos <= up ? pos + COUNT_WIDTH'(1) : pos - COUNT_WIDTH'(1);
        if (wr && rsel == 2'd2) ctrl <= bus.writedata[1:0];
      end
`ifdef MYOQUAD_VELOCITY_EN
    logic signed [15:0] acc, vel, d;
    assign d = !step ? 16'sd0 : up ? 16'sd1 : -16'sd1;
    // A sum of 0x8000 only arises from stepping past +-32767, so it doubles as the saturation test
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        acc <= '0;
        vel <= '0;
      end else if (vel_tick) begin
        vel <= acc;
        acc <= d;
      end else if (acc + d != 16'sh8000) acc <= acc + d;
    assign vel_word = 32'(vel);
`else
    assign vel_word = '0;
`endif
    assign rd_word[c] = rsel == 2'd0 ? 32'(signed'(pos)) :
                        rsel == 2'd1 ? {23'd0, fault, err} :
                        rsel == 2'd2 ? {30'd0, ctrl} : vel_word;
  end
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) rd_mux = ch == 6'(i) ? rd_word[i] : rd_mux;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bus.readdata <= '0;
    else if (bus.read) bus.readdata <= rd_mux;
endmodule

// File: tb/tb_myoquad_multi.sv
// tb_myoquad_multi: directed and randomized encoder traffic checked against a Gray-index step model
module tb_myoquad_multi;
  localparam int NCH = 8, CW = 16, FD = 3, VP = 1000;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [NCH-1:0] apos, aneg, bpos, bneg;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int st [NCH];
  logic [CW-1:0] m_pos [NCH];
  int m_err [NCH];
  logic m_fault [NCH];
  logic [1:0] m_ctrl [NCH];
  int n_chk = 0, n_err = 0, lat = 8, cyc = 0;
  logic [31:0] q;
  myoquad_multi_if bus();
  myoquad_multi #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(CW), .FILTER_DEPTH(FD), .VEL_PERIOD(VP)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .quad_apos(apos), .quad_aneg(aneg), .quad_bpos(bpos), .quad_bneg(bneg));
  always #5 clk = ~clk;
  always @(posedge clk or negedge reset_n) cyc <= !reset_n ? 0 : cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [7:0] ad(input int c, input int r);
    return {6'(c), 2'(r)};
  endfunction
  function automatic logic [31:0] sx(input logic [CW-1:0] v);
    return {{(32-CW){v[CW-1]}}, v};
  endfunction
  task automatic rd(input logic [7:0] a, output logic [31:0] r);
    bus.address = a;
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    r = bus.readdata;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    bus.address = a;
    bus.writedata = v;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask
  task automatic drive(input int c, input int idx);
    logic [1:0] ab;
    ab = gray[idx];
    apos[c] = ab[1];
    aneg[c] = ~ab[1];
    bpos[c] = ab[0];
    bneg[c] = ~ab[0];
  endtask
  task automatic model_move(input int c, input int idx);
    int dl, s;
    dl = (idx - st[c]) & 3;
    if (dl == 2) m_err[c] = m_err[c] < 255 ? m_err[c] + 1 : 255;
    else if (dl != 0 && m_ctrl[c][0]) begin
      s = ((dl == 1) != m_ctrl[c][1]) ? 1 : -1;
      m_pos[c] = m_pos[c] + CW'(s);
    end
    st[c] = idx;
  endtask
  task automatic move(input int c, input int idx);
    model_move(c, idx);
    drive(c, idx);
    tick(10);
  endtask
  task automatic move_wr(input int c, input int idx, input int r, input logic [31:0] v);
    model_move(c, idx);
    drive(c, idx);
    tick(lat - 2);
    wr(ad(c, r), v);
    tick(10);
  endtask
  task automatic fault(input int c, input int hold);
    aneg[c] = apos[c];
    tick(hold);
    aneg[c] = ~apos[c];
    m_fault[c] = 1'b1;
    tick(10);
  endtask
  task automatic calib(input int c);
    logic [31:0] old;
    int n;
    old = sx(m_pos[c]);
    model_move(c, (st[c] + 1) % 4);
    drive(c, st[c]);
    bus.address = ad(c, 0);
    bus.read = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.readdata == old && n < 40);
    bus.read = 1'b0;
    chk("first step", bus.readdata, sx(m_pos[c]));
    lat = n;
    tick(10);
  endtask
  task automatic check_ch(input int c);
    logic [31:0] r;
    rd(ad(c, 0), r);
    chk($sformatf("pos ch%0d", c), r, sx(m_pos[c]));
    rd(ad(c, 1), r);
    chk($sformatf("status ch%0d", c), r, {23'd0, m_fault[c], 8'(m_err[c])});
    rd(ad(c, 2), r);
    chk($sformatf("control ch%0d", c), r, {30'd0, m_ctrl[c]});
  endtask
  task automatic wait_off(input int off);
    int n;
    n = 0;
    while (cyc % VP != off && n < 2 * VP) begin
      @(negedge clk);
      n++;
    end
    chk("window wait expired", 32'(n >= 2 * VP), 32'd0);
  endtask
  task automatic reset_model;
    for (int c = 0; c < NCH; c++) begin
      m_pos[c] = '0;
      m_err[c] = 0;
      m_fault[c] = 1'b0;
      m_ctrl[c] = 2'b01;
    end
  endtask
  initial begin
    bus.address = '0;
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.writedata = '0;
    reset_model();
    for (int c = 0; c < NCH; c++) begin
      st[c] = 0;
      drive(c, 0);
    end
    tick(3);
    reset_n = 1'b1;
    tick(20);
    for (int c = 0; c < NCH; c += NCH - 1) begin
      check_ch(c);
      rd(ad(c, 3), q);
      chk("velocity after reset", q, 32'd0);
    end
    for (int k = 0; k < 40; k++) move(2, (st[2] + 1) % 4);
    rd(ad(2, 0), q);
    chk("ch2 +40", q, 32'd40);
    for (int k = 0; k < 45; k++) move(2, (st[2] + 3) % 4);
    rd(ad(2, 0), q);
    chk("ch2 -5", q, 32'hFFFFFFFB);
    check_ch(3);
    for (int k = 0; k < 3; k++) begin
      apos[0] = ~apos[0];
      aneg[0] = ~aneg[0];
      tick(2);
      apos[0] = ~apos[0];
      aneg[0] = ~aneg[0];
      tick(4);
      bpos[0] = ~bpos[0];
      bneg[0] = ~bneg[0];
      tick(2);
      bpos[0] = ~bpos[0];
      bneg[0] = ~bneg[0];
      tick(10);
    end
    check_ch(0);
    move(0, 2);
    check_ch(0);
    move(1, 2);
    fault(1, 5);
    check_ch(1);
    wr(ad(1, 1), 32'h100);
    m_fault[1] = 1'b0;
    check_ch(1);
    wr(ad(1, 1), 32'h200);
    m_err[1] = 0;
    check_ch(1);
    calib(4);
    wr(ad(4, 0), 32'h7FFF);
    m_pos[4] = 16'h7FFF;
    move(4, (st[4] + 1) % 4);
    rd(ad(4, 0), q);
    chk("ch4 wrap max+1", q, 32'hFFFF8000);
    move(4, (st[4] + 3) % 4);
    check_ch(4);
    move_wr(4, (st[4] + 1) % 4, 0, 32'h1234);
    m_pos[4] = 16'h1234;
    check_ch(4);
    wr(ad(5, 2), 32'h0);
    m_ctrl[5] = 2'b00;
    for (int k = 0; k < 3; k++) move(5, (st[5] + 1) % 4);
    wr(ad(5, 2), 32'h1);
    m_ctrl[5] = 2'b01;
    tick(10);
    check_ch(5);
    wr(ad(5, 2), 32'h3);
    m_ctrl[5] = 2'b11;
    for (int k = 0; k < 2; k++) move(5, (st[5] + 1) % 4);
    check_ch(5);
    rd(ad(9, 2), q);
    chk("out of range read", q, 32'd0);
    wr(ad(9, 0), 32'hABCD);
    check_ch(1);
    rd(ad(5, 2), q);
    tick(5);
    chk("readdata hold", bus.readdata, {30'd0, m_ctrl[5]});
    for (int k = 0; k < 260; k++) move(7, (st[7] + 2) % 4);
    check_ch(7);
    move_wr(7, (st[7] + 2) % 4, 1, 32'h200);
    m_err[7] = 1;
    check_ch(7);
    for (int it = 0; it < 150; it++) begin
      int c, a;
      logic [31:0] v;
      c = $urandom_range(0, NCH - 2);
      if (c == 6) c = 7;
      a = $urandom_range(0, 19);
      v = $urandom;
      if (a < 12) move(c, (st[c] + (a[0] ? 1 : 3)) % 4);
      else if (a == 12) move(c, (st[c] + 2) % 4);
      else if (a < 15) begin
        m_ctrl[c] = v[1:0];
        wr(ad(c, 2), v);
      end else if (a == 15) begin
        m_pos[c] = v[CW-1:0];
        wr(ad(c, 0), v);
      end else if (a == 16) fault(c, 6);
      else if (a == 17) begin
        if (v[8]) m_fault[c] = 1'b0;
        if (v[9]) m_err[c] = 0;
        wr(ad(c, 1), v);
      end else check_ch(c);
    end
    for (int c = 0; c < NCH; c++) check_ch(c);
    wait_off(100);
    for (int k = 0; k < 25; k++) move(6, (st[6] + 1) % 4);
    wait_off(50);
    rd(ad(6, 3), q);
`ifdef MYOQUAD_VELOCITY_EN
    chk("velocity 25 steps", q, 32'd25);
`else
    chk("velocity absent", q, 32'd0);
`endif
    check_ch(6);
    wait_off(50);
    rd(ad(6, 3), q);
    chk("velocity idle window", q, 32'd0);
    wr(ad(0, 0), 32'h55);
    rd(ad(0, 0), q);
    chk("pos before reset", q, 32'h55);
    #2 reset_n = 1'b0;
    #1 chk("async readdata clear", bus.readdata, 32'd0);
    st[5] = (st[5] + 2) % 4;
    drive(5, st[5]);
    reset_model();
    @(negedge clk);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    for (int c = 0; c < NCH; c++) check_ch(c);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
